// File: rtl/press_logic.sv
// rtl/press_logic.sv - button press synchronizer, hold-duration timer and release-time position latch
module press_logic #(
    parameter int TICK_DIV = 4,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN,
    input  logic [1:0] random,
    output logic       is_pressing,
    output logic [3:0] press_time,
    output logic [1:0] position
);

    typedef enum logic {
        IDLE     = 1'b0,
        PRESSING = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       TIME_MAX = 4'd15;

    state_t           state;
    logic             btn_meta;
    logic             btn_s;
    logic [DIV_W-1:0] divider;

    // Two-flop synchronizer for the asynchronous push-button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= BTN;
            btn_s    <= btn_meta;
        end
    end

    // Press state machine: hold-time divider/counter and position capture on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_pressing <= 1'b0;
            press_time  <= 4'd0;
            divider     <= '0;
            position    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state       <= PRESSING;
                        is_pressing <= 1'b1;
                        press_time  <= 4'd0;
                        divider     <= '0;
                    end
                end
                PRESSING: begin
                    // The exit edge still counts as a held cycle
                    if (divider == DIV_MAX) begin
                        divider <= '0;
                        if (press_time != TIME_MAX) begin
                            press_time <= press_time + 4'd1;
                        end
                    end else begin
                        divider <= divider + 1'b1;
                    end
                    if (!btn_s) begin
                        state       <= IDLE;
                        is_pressing <= 1'b0;
                        position    <= random;
                    end
                end
                default: begin
                    state       <= IDLE;
                    is_pressing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_logic.sv
// tb/tb_press_logic.sv - self-checking bench for press_logic
module tb_press_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       BTN;
    logic       btn1;
    logic [1:0] random;
    logic       ip0, ip1;
    logic [3:0] pt0, pt1;
    logic [1:0] pos0, pos1;

    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    press_logic #(.TICK_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .BTN(BTN), .random(random),
        .is_pressing(ip0), .press_time(pt0), .position(pos0)
    );

    press_logic #(.TICK_DIV(1), .DIV_W(16)) dut1 (
        .clk(clk), .rst(rst), .BTN(btn1), .random(random),
        .is_pressing(ip1), .press_time(pt1), .position(pos1)
    );

    typedef struct {
        logic       btn;
        logic [1:0] rnd;
        logic       ip;
        logic [3:0] pt;
        logic [1:0] pos;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic b, logic [1:0] r, logic ip, logic [3:0] pt, logic [1:0] pos);
        vec_t v;
        v.btn = b; v.rnd = r; v.ip = ip; v.pt = pt; v.pos = pos;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic ip, logic [3:0] pt, logic [1:0] pos);
        chk({name, "_ip"}, {7'd0, ip0}, {7'd0, ip});
        chk({name, "_pt"}, {4'd0, pt0}, {4'd0, pt});
        chk({name, "_pos"}, {6'd0, pos0}, {6'd0, pos});
    endtask

    initial begin
        // Single press of 10 cycles, release sampled at exit edge (vector 12)
        add(1,0, 0,0,0); add(1,1, 0,0,0); add(1,2, 1,0,0); add(1,3, 1,0,0);
        add(1,0, 1,0,0); add(1,1, 1,0,0); add(1,2, 1,1,0); add(1,3, 1,1,0);
        add(1,0, 1,1,0); add(1,1, 1,1,0); add(0,2, 1,2,0); add(0,1, 1,2,0);
        add(0,3, 0,2,3); add(0,0, 0,2,3); add(0,1, 0,2,3);
        // Second press of 5 cycles: cleared at start, ends at 1, new position 2
        add(1,2, 0,2,3); add(1,2, 0,2,3); add(1,2, 1,0,3); add(1,1, 1,0,3);
        add(1,0, 1,0,3); add(0,0, 1,0,3); add(0,0, 1,1,3); add(0,2, 0,1,2);
        add(0,1, 0,1,2); add(0,3, 0,1,2);
        // Two 1-cycle presses back to back with an IDLE cycle between them
        add(1,0, 0,1,2); add(0,0, 0,1,2); add(1,0, 1,0,2); add(0,1, 0,0,1);
        add(0,0, 1,0,1); add(0,3, 0,0,3); add(0,0, 0,0,3);

        rst = 1'b1; BTN = 1'b1; btn1 = 1'b1; random = 2'd3;
        #5;
        chk_all("reset_async", 1'b0, 4'd0, 2'd0);
        repeat (3) @(negedge clk);
        chk_all("reset_btn_ignored", 1'b0, 4'd0, 2'd0);
        chk("reset_dut1_ip", {7'd0, ip1}, 8'd0);
        BTN = 1'b0; btn1 = 1'b0; random = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("idle_after_reset", 1'b0, 4'd0, 2'd0);

        foreach (tbl[i]) begin
            BTN = tbl[i].btn;
            random = tbl[i].rnd;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].ip, tbl[i].pt, tbl[i].pos);
        end

        // Sub-cycle glitch that falls between clock edges
        #5 BTN = 1'b1;
        #5 BTN = 1'b0;
        repeat (4) @(negedge clk);
        chk_all("glitch", 1'b0, 4'd0, 2'd3);

        // Saturation: 80-cycle hold
        for (int i = 0; i < 90; i++) begin
            BTN = (i < 80);
            random = 2'd1;
            @(negedge clk);
            if (i == 61) chk_all("sat_61", 1'b1, 4'd14, 2'd3);
            if (i == 62) chk_all("sat_62", 1'b1, 4'd15, 2'd3);
            if (i == 81) chk_all("sat_81", 1'b1, 4'd15, 2'd3);
            if (i == 82) chk_all("sat_release", 1'b0, 4'd15, 2'd1);
            if (i == 89) chk_all("sat_hold", 1'b0, 4'd15, 2'd1);
        end

        // Reset mid-press, then re-press through the synchronizer
        BTN = 1'b1; random = 2'd2;
        repeat (5) @(negedge clk);
        chk("midrst_pressing", {7'd0, ip0}, 8'd1);
        #5 rst = 1'b1;
        #1;
        chk_all("midrst_async", 1'b0, 4'd0, 2'd0);
        @(negedge clk);
        chk_all("midrst_held", 1'b0, 4'd0, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_edge1", {7'd0, ip0}, 8'd0);
        @(negedge clk);
        chk("midrst_edge2", {7'd0, ip0}, 8'd0);
        @(negedge clk);
        chk("midrst_edge3", {7'd0, ip0}, 8'd1);
        BTN = 1'b0;
        repeat (5) @(negedge clk);

        // TICK_DIV=1, single-cycle pulse
        btn1 = 1'b1; random = 2'd0;
        @(negedge clk);
        btn1 = 1'b0;
        @(negedge clk);
        chk("td1_edge1_ip", {7'd0, ip1}, 8'd0);
        random = 2'd2;
        @(negedge clk);
        chk("td1_edge2_ip", {7'd0, ip1}, 8'd1);
        chk("td1_edge2_pt", {4'd0, pt1}, 8'd0);
        @(negedge clk);
        chk("td1_exit_ip", {7'd0, ip1}, 8'd0);
        chk("td1_exit_pt", {4'd0, pt1}, 8'd1);
        chk("td1_exit_pos", {6'd0, pos1}, 8'd2);
        random = 2'd0;
        @(negedge clk);
        chk("td1_hold_pt", {4'd0, pt1}, 8'd1);
        chk("td1_hold_pos", {6'd0, pos1}, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
